// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the multiplexed 7-segment scanner:
//               converter state enum, blank segment constant, digit encoder
//               and a power-of-ten constant function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Segment pattern for a dark digit, {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNAP   = 3'd1,
        LOAD   = 3'd2,
        SHIFT  = 3'd3,
        STORE  = 3'd4,
        COMMIT = 3'd5
    } conv_state_t;

    // Active-high segment map for one BCD nibble; dp bit is always 0 here.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // 10^n, evaluated at elaboration time for the clamp limit
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dd_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dd_conv
// Description : Sequential shift-add-3 (double-dabble) binary to BCD converter
//               for one field. Loads on start_i, then performs VAL_W
//               add-3/shift steps, one per clock.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start_i       - load bin_i and begin a conversion
//               bin_i         - binary value (already clamped by caller)
//               done_o        - high during the final shift step; bcd_o is
//                               valid from the following cycle
//               bcd_o         - DIGITS packed BCD nibbles, nibble 0 = ones
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dd_conv #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [VAL_W-1:0]      bin_i,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int C_CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        // Add-3 correction on every nibble that would overflow 9 after doubling
        w_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end

        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = C_CNT_W'(VAL_W);
        end else if (cnt_q != '0) begin
            bcd_d = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[VAL_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == C_CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed 7-segment scanner. Snapshots NUM_FIELDS binary
//               values, converts them one at a time into a back buffer, then
//               commits a coherent frame to the front buffer which is scanned
//               onto NUM_FIELDS*DIGITS digits with leading-zero blanking,
//               per-field blink, decimal points and an anti-ghost gap.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               tick_scan_i    - strobe, advance scan digit
//               tick_blink_i   - strobe, toggle blink phase
//               field_val_i    - packed field values, field f at [f*VAL_W +: VAL_W]
//               lzb_en_i       - per-field leading-zero blanking enable
//               blink_en_i     - per-field blink enable
//               dp_mask_i      - per-digit decimal point enable
//               seg_data_o     - {dp,g,f,e,d,c,b,a}, active high, registered
//               seg_com_o      - digit commons, active low, registered
//               frame_done_o   - one-cycle pulse while a frame is committed
//               conv_busy_o    - high whenever the converter is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int DIGITS     = 4,
    parameter int VAL_W      = 14,
    parameter int BLANK_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_scan_i,
    input  logic                          tick_blink_i,
    input  logic [NUM_FIELDS*VAL_W-1:0]   field_val_i,
    input  logic [NUM_FIELDS-1:0]         lzb_en_i,
    input  logic [NUM_FIELDS-1:0]         blink_en_i,
    input  logic [NUM_FIELDS*DIGITS-1:0]  dp_mask_i,
    output logic [7:0]                    seg_data_o,
    output logic [NUM_FIELDS*DIGITS-1:0]  seg_com_o,
    output logic                          frame_done_o,
    output logic                          conv_busy_o
);

    localparam int          C_NUM_DIG = NUM_FIELDS * DIGITS;
    localparam int          C_SCAN_W  = (C_NUM_DIG > 1) ? $clog2(C_NUM_DIG) : 1;
    localparam int          C_FIDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int          C_BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int unsigned C_MAX_VAL = pow10(DIGITS) - 1;

    // ------------------------------------------------------------------
    // Converter sequencer
    // ------------------------------------------------------------------
    conv_state_t                 state_q, state_d;
    logic [NUM_FIELDS*VAL_W-1:0] snap_q;
    logic [C_FIDX_W-1:0]         fidx_q;
    logic [4*C_NUM_DIG-1:0]      back_q;
    logic [4*C_NUM_DIG-1:0]      front_q;

    logic [VAL_W-1:0]            w_field_raw;
    logic [VAL_W-1:0]            w_conv_bin;
    logic                        w_conv_start;
    logic                        w_conv_done;
    logic [4*DIGITS-1:0]         w_conv_bcd;

    assign w_field_raw  = snap_q[fidx_q*VAL_W +: VAL_W];
    // Values beyond what DIGITS can show saturate at all nines
    assign w_conv_bin   = (32'(w_field_raw) > C_MAX_VAL) ? VAL_W'(C_MAX_VAL) : w_field_raw;
    assign w_conv_start = (state_q == LOAD);

    bcd_dd_conv #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (w_conv_start),
        .bin_i   (w_conv_bin),
        .done_o  (w_conv_done),
        .bcd_o   (w_conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = SNAP;
            SNAP:    state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (w_conv_done) state_d = STORE;
            STORE:   state_d = (fidx_q == C_FIDX_W'(NUM_FIELDS - 1)) ? COMMIT : LOAD;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q  <= '0;
            fidx_q  <= '0;
            back_q  <= '0;
            front_q <= '0;
        end else begin
            case (state_q)
                SNAP: begin
                    snap_q <= field_val_i;
                    fidx_q <= '0;
                end
                STORE: begin
                    back_q[fidx_q*4*DIGITS +: 4*DIGITS] <= w_conv_bcd;
                    fidx_q <= fidx_q + C_FIDX_W'(1);
                end
                COMMIT: front_q <= back_q;
                default: ;
            endcase
        end
    end

    assign frame_done_o = (state_q == COMMIT);
    assign conv_busy_o  = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Scan counter, anti-ghost gap and blink phase
    // ------------------------------------------------------------------
    logic [C_SCAN_W-1:0]  scan_idx_q;
    logic [C_BLANK_W-1:0] blank_cnt_q;
    logic                 blink_phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_q    <= '0;
            blank_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            // A tick inside the gap still advances and restarts the gap
            if (tick_scan_i) begin
                scan_idx_q  <= (scan_idx_q == C_SCAN_W'(C_NUM_DIG - 1)) ? '0
                                                                       : scan_idx_q + C_SCAN_W'(1);
                blank_cnt_q <= C_BLANK_W'(BLANK_CYC);
            end else if (blank_cnt_q != '0) begin
                blank_cnt_q <= blank_cnt_q - C_BLANK_W'(1);
            end
            if (tick_blink_i) begin
                blink_phase_q <= ~blink_phase_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    int                    w_digit;
    int                    w_field;
    int                    w_nib_pos;
    logic [4*DIGITS-1:0]   w_field_bcd;
    logic [3:0]            w_nib;
    logic                  w_upper_zero;
    logic                  w_lz_blank;
    logic                  w_blink;
    logic [7:0]            seg_data_d, seg_data_q;
    logic [C_NUM_DIG-1:0]  seg_com_d,  seg_com_q;

    always_comb begin
        w_digit     = int'(scan_idx_q);
        w_field     = w_digit / DIGITS;
        w_nib_pos   = w_digit % DIGITS;
        w_field_bcd = front_q[w_field*4*DIGITS +: 4*DIGITS];
        w_nib       = w_field_bcd[w_nib_pos*4 +: 4];

        // Nibble is a leading zero when it and every higher nibble are zero
        w_upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= w_nib_pos) && (w_field_bcd[j*4 +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_lz_blank = lzb_en_i[w_field] && (w_nib_pos != 0) && w_upper_zero;
        w_blink    = blink_phase_q && blink_en_i[w_field];

        seg_com_d  = '1;
        seg_data_d = SEG_BLANK;
        if (blank_cnt_q == '0) begin
            seg_com_d[w_digit] = 1'b0;
            if (!w_blink) begin
                seg_data_d    = w_lz_blank ? SEG_BLANK : seg_encode(w_nib);
                // Decimal point survives leading-zero blanking
                seg_data_d[7] = dp_mask_i[w_digit];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data_q <= SEG_BLANK;
            seg_com_q  <= '1;
        end else begin
            seg_data_q <= seg_data_d;
            seg_com_q  <= seg_com_d;
        end
    end

    assign seg_data_o = seg_data_q;
    assign seg_com_o  = seg_com_q;

endmodule
`default_nettype wire
